mem_port_arbiter: RTL and testbench

Sequential arbiter sharing the single data-memory bus between the instruction-fetch port and the MEM-stage load/store port of the 32I pipeline. It latches one request at a time and drives the bus until the memory acknowledges or a timeout expires, then returns read data with a one-cycle ready pulse. It checks alignment, prevents fetch starvation, and provides a stall indication to the pipeline.

---
 rtl/mem_port_arbiter_if.sv | 31 +++
 rtl/mem_port_arbiter.sv | 88 ++++++++
 tb/tb_mem_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side signals of the shared data-memory bus
interface mem_port_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_ready;
   logic        d_req;
   logic        d_write;
   logic [1:0]  d_size;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        err;
   logic        stall;
   logic        m_mreq;
   logic        m_write;
   logic [1:0]  m_size;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;
   logic        m_ack;
   modport master (
      output i_req, i_addr, d_req, d_write, d_size, d_addr, d_wdata, m_rdata, m_ack,
      input  i_rdata, i_ready, d_rdata, d_ready, err, stall, m_mreq, m_write, m_size, m_addr, m_wdata
   );
   modport slave (
      input  i_req, i_addr, d_req, d_write, d_size, d_addr, d_wdata, m_rdata, m_ack,
      output i_rdata, i_ready, d_rdata, d_ready, err, stall, m_mreq, m_write, m_size, m_addr, m_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between fetch and load/store, data-first with a streak limit
module mem_port_arbiter #(
   parameter int TIMEOUT  = 255,
   parameter int D_STREAK = 4
) (
   input logic clk,
   input logic rst_n,
   mem_port_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
   logic [1:0]  state;
   logic        owner;
   logic [15:0] tcnt, streak;
   logic        gd, gi, mis, fin;
   logic [31:0] g_addr;
   logic [1:0]  g_size;
   always_comb begin
      gd = bus.d_req && (streak < 16'(D_STREAK) || !bus.i_req);
      gi = bus.i_req && !gd;
      g_addr = gd ? bus.d_addr : bus.i_addr;
      g_size = gd ? bus.d_size : 2'b00;
      mis = g_size == 2'b01 ? g_addr[0] : g_size == 2'b10 ? 1'b0 : g_addr[1:0] != 2'b00;
      fin = bus.m_ack || tcnt == 16'(TIMEOUT - 1);
   end
   assign bus.stall = (bus.i_req && !bus.i_ready) || (bus.d_req && !bus.d_ready);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         owner       <= 1'b0;
         tcnt        <= '0;
         streak      <= '0;
         bus.m_mreq  <= 1'b0;
         bus.m_write <= 1'b0;
         bus.m_size  <= 2'b00;
         bus.m_addr  <= '0;
         bus.m_wdata <= '0;
         bus.i_rdata <= '0;
         bus.d_rdata <= '0;
         bus.i_ready <= 1'b0;
         bus.d_ready <= 1'b0;
         bus.err     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (gd || gi) begin
               owner  <= gd;
               // a data grant only happens below the limit while fetch waits, so no explicit clamp
               streak <= (gd && bus.i_req) ? streak + 16'd1 : 16'd0;
               if (mis) begin
                  state       <= DONE;
                  bus.err     <= 1'b1;
                  bus.i_ready <= gi;
                  bus.d_ready <= gd;
                  if (gd) bus.d_rdata <= '0;
                  else bus.i_rdata <= '0;
               end else begin
                  state       <= BUSY;
                  tcnt        <= '0;
                  bus.m_mreq  <= 1'b1;
                  bus.m_write <= gd && bus.d_write;
                  bus.m_size  <= g_size;
                  bus.m_addr  <= g_addr;
                  bus.m_wdata <= gd ? bus.d_wdata : '0;
               end
            end
            BUSY: if (fin) begin
               state       <= DONE;
               bus.m_mreq  <= 1'b0;
               bus.m_write <= 1'b0;
               bus.m_wdata <= '0;
               bus.err     <= !bus.m_ack;
               bus.i_ready <= !owner;
               bus.d_ready <= owner;
               if (owner) bus.d_rdata <= bus.m_ack ? bus.m_rdata : '0;
               else bus.i_rdata <= bus.m_ack ? bus.m_rdata : '0;
            end else begin
               tcnt <= tcnt + 16'd1;
            end
            DONE: begin
               state       <= IDLE;
               bus.i_ready <= 1'b0;
               bus.d_ready <= 1'b0;
               bus.err     <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_mem_port_arbiter;
   localparam int TO = 8;
   localparam int DS = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   mem_port_arbiter_if bus();
   mem_port_arbiter #(.TIMEOUT(TO), .D_STREAK(DS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int run = 0;
   int last_run = 0;
   bit seen_i, seen_d, stop, deaf, was_mreq;

   // model: the access in flight, what the outputs must be this cycle
   bit          on_bus, resp, own_d;
   int          bus_cycles, streak;
   logic        e_mreq, e_write, e_iready, e_dready, e_err;
   logic [1:0]  e_size;
   logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int access_bytes(input logic [1:0] s);
      return s == 2'b01 ? 2 : s == 2'b10 ? 1 : 4;
   endfunction

   task automatic model_reset();
      on_bus = 0; resp = 0; own_d = 0; bus_cycles = 0; streak = 0;
      e_mreq = 0; e_write = 0; e_iready = 0; e_dready = 0; e_err = 0;
      e_size = 0; e_addr = 0; e_wdata = 0; e_irdata = 0; e_drdata = 0;
   endtask

   task automatic finish_access(input bit is_err, input logic [31:0] data);
      on_bus = 0;
      resp = 1;
      e_err = is_err;
      if (own_d) begin e_dready = 1; e_drdata = data; end
      else begin e_iready = 1; e_irdata = data; end
   endtask

   task automatic model_step();
      logic [31:0] a;
      logic [1:0]  sz;
      e_iready = 0; e_dready = 0; e_err = 0;
      if (resp) resp = 0;
      else if (on_bus) begin
         bus_cycles++;
         if (bus.m_ack) finish_access(0, bus.m_rdata);
         else if (bus_cycles == TO) finish_access(1, 0);
      end else if (bus.i_req || bus.d_req) begin
         own_d = bus.d_req && (!bus.i_req || streak < DS);
         streak = (own_d && bus.i_req) ? ((streak + 1 > DS) ? DS : streak + 1) : 0;
         a = own_d ? bus.d_addr : bus.i_addr;
         sz = own_d ? bus.d_size : 2'b00;
         if (a % access_bytes(sz) != 0) finish_access(1, 0);
         else begin
            on_bus = 1; bus_cycles = 0;
            e_addr = a; e_size = sz;
            e_write = own_d && bus.d_write;
            e_wdata = own_d ? bus.d_wdata : 32'h0;
         end
      end
      if (!on_bus) begin e_write = 0; e_wdata = 0; end
      e_mreq = on_bus;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         chk("m_mreq", 32'(bus.m_mreq), 32'(e_mreq));
         chk("m_write", 32'(bus.m_write), 32'(e_write));
         chk("m_wdata", bus.m_wdata, e_wdata);
         if (e_mreq) begin
            chk("m_addr", bus.m_addr, e_addr);
            chk("m_size", 32'(bus.m_size), 32'(e_size));
         end
         chk("i_ready", 32'(bus.i_ready), 32'(e_iready));
         chk("d_ready", 32'(bus.d_ready), 32'(e_dready));
         chk("err", 32'(bus.err), 32'(e_err));
         if (e_iready) chk("i_rdata", bus.i_rdata, e_irdata);
         if (e_dready) chk("d_rdata", bus.d_rdata, e_drdata);
         chk("stall", 32'(bus.stall), 32'((bus.i_req && !e_iready) || (bus.d_req && !e_dready)));
      end
   end

   initial forever begin
      @(negedge clk);
      seen_i = bus.i_ready;
      seen_d = bus.d_ready;
      if (!rst_n) run = 0;
      else if (bus.m_mreq) run++;
      else if (run != 0) begin last_run = run; run = 0; end
   end

   task automatic new_fetch();
      logic [31:0] a;
      a = $urandom;
      a[1:0] = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bus.i_req = 1; bus.i_addr = a;
   endtask

   task automatic new_data();
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      bus.d_req = 1; bus.d_addr = a; bus.d_wdata = $urandom;
      bus.d_write = $urandom_range(0, 1) == 1;
      bus.d_size = 2'($urandom_range(0, 3));
   endtask

   task automatic rand_cycle();
      if (bus.i_req) begin
         if (seen_i) begin
            if (!stop && $urandom_range(0, 1) == 1) new_fetch();
            else bus.i_req = 0;
         end
      end else if (!stop && $urandom_range(0, 2) == 0) new_fetch();
      if (bus.d_req) begin
         if (seen_d) begin
            if (!stop && $urandom_range(0, 1) == 1) new_data();
            else bus.d_req = 0;
         end
      end else if (!stop && $urandom_range(0, 2) == 0) new_data();
      if (bus.m_mreq && !was_mreq) deaf = $urandom_range(0, 7) == 0;
      was_mreq = bus.m_mreq;
      bus.m_ack = bus.m_mreq ? (!deaf && $urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      bus.m_rdata = $urandom;
   endtask

   initial begin
      logic [9:0] seq;
      int n;
      bit was;
      bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_write = 0; bus.d_size = 0;
      bus.d_addr = 0; bus.d_wdata = 0; bus.m_rdata = 0; bus.m_ack = 0;
      #3;
      chk("rst m_mreq", 32'(bus.m_mreq), 0);
      chk("rst m_write", 32'(bus.m_write), 0);
      chk("rst m_addr", bus.m_addr, 0);
      chk("rst m_wdata", bus.m_wdata, 0);
      chk("rst m_size", 32'(bus.m_size), 0);
      chk("rst i_ready", 32'(bus.i_ready), 0);
      chk("rst d_ready", 32'(bus.d_ready), 0);
      chk("rst err", 32'(bus.err), 0);
      chk("rst rdata", bus.i_rdata | bus.d_rdata, 0);
      #14 rst_n = 1;
      step();

      // single fetch, ack on the third bus cycle
      bus.i_req = 1; bus.i_addr = 32'h100;
      step();
      chk("fetch mreq", 32'(bus.m_mreq), 1);
      chk("fetch addr", bus.m_addr, 32'h100);
      step();
      step();
      bus.m_ack = 1; bus.m_rdata = 32'h13;
      step();
      bus.m_ack = 0;
      chk("fetch ready", 32'(bus.i_ready), 1);
      chk("fetch rdata", bus.i_rdata, 32'h13);
      chk("fetch err", 32'(bus.err), 0);
      step();
      bus.i_req = 0;
      chk("fetch pulse", 32'(bus.i_ready), 0);
      chk("fetch mreq cycles", 32'(last_run), 3);

      // contention: data first, then fetch
      bus.i_req = 1; bus.i_addr = 32'h104;
      bus.d_req = 1; bus.d_write = 0; bus.d_size = 0; bus.d_addr = 32'h2000;
      step();
      step();
      chk("cont data addr", bus.m_addr, 32'h2000);
      bus.m_ack = 1; bus.m_rdata = 32'hCAFE0001;
      step();
      bus.m_ack = 0;
      chk("cont d_ready", 32'(bus.d_ready), 1);
      chk("cont d_rdata", bus.d_rdata, 32'hCAFE0001);
      chk("cont stall", 32'(bus.stall), 1);
      step();
      bus.d_req = 0;
      step();
      chk("cont fetch addr", bus.m_addr, 32'h104);
      bus.m_ack = 1; bus.m_rdata = 32'h93;
      step();
      bus.m_ack = 0;
      chk("cont i_ready", 32'(bus.i_ready), 1);
      chk("cont stall end", 32'(bus.stall), 0);
      step();
      bus.i_req = 0;

      // starvation guard: four data grants then one fetch
      bus.i_req = 1; bus.i_addr = 32'h400;
      bus.d_req = 1; bus.d_write = 1; bus.d_size = 0; bus.d_addr = 32'h3000; bus.d_wdata = 32'h5A5A;
      seq = '0; n = 0; was = 0;
      for (int c = 0; c < 200 && n < 10; c++) begin
         step();
         bus.m_ack = bus.m_mreq;
         if (bus.m_mreq && !was) begin
            seq[n] = bus.m_addr == 32'h400;
            n++;
         end
         was = bus.m_mreq;
      end
      step();
      bus.m_ack = 0;
      step();
      bus.i_req = 0; bus.d_req = 0;
      chk("streak grants", 32'(n), 10);
      chk("streak order", 32'(seq), 32'h210);

      // misaligned half store
      step();
      bus.d_req = 1; bus.d_write = 1; bus.d_size = 2'b01; bus.d_addr = 32'h1001; bus.d_wdata = 32'hBEEF;
      step();
      chk("mis mreq", 32'(bus.m_mreq), 0);
      chk("mis d_ready", 32'(bus.d_ready), 1);
      chk("mis err", 32'(bus.err), 1);
      chk("mis d_rdata", bus.d_rdata, 0);
      step();
      bus.d_req = 0;
      chk("mis pulse", 32'(bus.d_ready), 0);

      // timeout, then a late ack
      bus.d_req = 1; bus.d_write = 0; bus.d_size = 0; bus.d_addr = 32'h3000;
      for (int c = 0; c < 30; c++) begin
         step();
         if (bus.d_ready) break;
      end
      chk("to d_ready", 32'(bus.d_ready), 1);
      chk("to err", 32'(bus.err), 1);
      chk("to d_rdata", bus.d_rdata, 0);
      step();
      bus.d_req = 0; bus.m_ack = 1;
      chk("to mreq cycles", 32'(last_run), TO);
      step();
      bus.m_ack = 0;
      chk("late ack mreq", 32'(bus.m_mreq), 0);
      chk("late ack ready", 32'(bus.d_ready), 0);

      // reset in the middle of a bus access
      bus.i_req = 1; bus.i_addr = 32'h200;
      step();
      step();
      chk("pre-rst mreq", 32'(bus.m_mreq), 1);
      #2 rst_n = 0;
      #1;
      chk("mid-rst mreq", 32'(bus.m_mreq), 0);
      chk("mid-rst m_addr", bus.m_addr, 0);
      chk("mid-rst i_rdata", bus.i_rdata, 0);
      chk("mid-rst i_ready", 32'(bus.i_ready), 0);
      bus.i_req = 0;
      @(negedge clk);
      #2 rst_n = 1;
      step();
      bus.i_req = 1; bus.i_addr = 32'h208;
      step();
      chk("post-rst mreq", 32'(bus.m_mreq), 1);
      bus.m_ack = 1; bus.m_rdata = 32'h55;
      step();
      bus.m_ack = 0;
      chk("post-rst i_ready", 32'(bus.i_ready), 1);
      chk("post-rst i_rdata", bus.i_rdata, 32'h55);
      step();
      bus.i_req = 0;

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         step();
         rand_cycle();
      end
      stop = 1;
      for (int c = 0; c < 300 && (bus.i_req || bus.d_req); c++) begin
         step();
         rand_cycle();
      end
      chk("drain", 32'(bus.i_req || bus.d_req), 0);
      bus.m_ack = 0;
      step();
      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
